// File: rtl/temp_alarm_pkg.sv
// rtl/temp_alarm_pkg.sv - alarm state encoding and fan duty constants for temp_alarm_ctrl
package temp_alarm_pkg;

    typedef enum logic [1:0] {
        ST_NORMAL = 2'b00,
        ST_WARN   = 2'b01,
        ST_CRIT   = 2'b10
    } alarm_state_t;

    localparam logic [7:0] FAN_NORMAL = 8'd0;
    localparam logic [7:0] FAN_WARN   = 8'd128;
    localparam logic [7:0] FAN_CRIT   = 8'd255;

    function automatic logic [7:0] duty_of(input alarm_state_t s);
        case (s)
            ST_WARN: return FAN_WARN;
            ST_CRIT: return FAN_CRIT;
            default: return FAN_NORMAL;
        endcase
    endfunction

endpackage

// File: rtl/temp_debounce.sv
// rtl/temp_debounce.sv - saturating consecutive-sample counter with clear and terminal count
module temp_debounce #(
    parameter int TC = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic tc
);

    localparam logic [3:0] TC_LAST = 4'(TC - 1);

    logic [3:0] count;

    // Terminal count fires on the edge that sees the TC-th qualifying sample.
    assign tc = inc && (count == TC_LAST);

    always_ff @(posedge clk) begin
        if (!rst || clr || tc) begin
            count <= 4'd0;
        end else if (inc && (count != 4'hF)) begin
            count <= count + 4'd1;
        end
    end

endmodule

// File: rtl/temp_alarm_ctrl.sv
// rtl/temp_alarm_ctrl.sv - debounced temperature alarm FSM; TEMP_ALARM_STATS_EN enables min/max stats
module temp_alarm_ctrl
    import temp_alarm_pkg::*;
#(
    parameter logic [7:0] WARN_TH  = 8'd60,
    parameter logic [7:0] CRIT_TH  = 8'd80,
    parameter logic [7:0] HYST     = 8'd5,
    parameter int         DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] temp_in,
    input  logic       temp_valid,
    input  logic       stats_clr,
    output logic [1:0] alarm_state,
    output logic       warn,
    output logic       crit,
    output logic [7:0] fan_duty,
    output logic       irq,
    output logic [7:0] temp_min,
    output logic [7:0] temp_max
);

    // Release levels saturate at zero so a small threshold never wraps.
    localparam logic [7:0] WARN_LO = (WARN_TH > HYST) ? WARN_TH - HYST : 8'd0;
    localparam logic [7:0] CRIT_LO = (CRIT_TH > HYST) ? CRIT_TH - HYST : 8'd0;

    alarm_state_t state;
    alarm_state_t target;
    logic         qual;
    logic         fire;
    logic         changed;

    always_comb begin
        qual   = 1'b0;
        target = state;
        case (state)
            ST_NORMAL: begin
                if (temp_in >= CRIT_TH) begin
                    qual   = 1'b1;
                    target = ST_CRIT;
                end else if (temp_in >= WARN_TH) begin
                    qual   = 1'b1;
                    target = ST_WARN;
                end
            end
            ST_WARN: begin
                if (temp_in >= CRIT_TH) begin
                    qual   = 1'b1;
                    target = ST_CRIT;
                end else if (temp_in < WARN_LO) begin
                    qual   = 1'b1;
                    target = ST_NORMAL;
                end
            end
            ST_CRIT: begin
                if (temp_in < CRIT_LO) begin
                    qual   = 1'b1;
                    target = ST_WARN;
                end
            end
            default: ;
        endcase
    end

    temp_debounce #(.TC(DEBOUNCE)) u_debounce (
        .clk (clk),
        .rst (rst),
        .inc (temp_valid && qual),
        .clr (temp_valid && !qual),
        .tc  (fire)
    );

    // irq trails the state change by one cycle via the changed flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_NORMAL;
            warn     <= 1'b0;
            crit     <= 1'b0;
            fan_duty <= FAN_NORMAL;
            changed  <= 1'b0;
            irq      <= 1'b0;
        end else begin
            changed <= fire;
            irq     <= changed;
            if (fire) begin
                state    <= target;
                warn     <= (target != ST_NORMAL);
                crit     <= (target == ST_CRIT);
                fan_duty <= duty_of(target);
            end
        end
    end

    assign alarm_state = state;

`ifdef TEMP_ALARM_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst || stats_clr) begin
            temp_min <= 8'hFF;
            temp_max <= 8'h00;
        end else if (temp_valid) begin
            if (temp_in < temp_min) temp_min <= temp_in;
            if (temp_in > temp_max) temp_max <= temp_in;
        end
    end
`else
    logic unused_stats_clr;
    assign unused_stats_clr = stats_clr;
    assign temp_min = 8'h00;
    assign temp_max = 8'h00;
`endif

endmodule

// File: tb/tb_temp_alarm_ctrl.sv
// tb/tb_temp_alarm_ctrl.sv - self-checking bench for temp_alarm_ctrl
module tb_temp_alarm_ctrl;

    localparam int WARN_TH  = 60;
    localparam int CRIT_TH  = 80;
    localparam int HYST     = 5;
    localparam int DEBOUNCE = 4;
`ifdef TEMP_ALARM_STATS_EN
    localparam int RST_MIN = 255;
`else
    localparam int RST_MIN = 0;
`endif

    logic       clk;
    logic       rst;
    logic [7:0] temp_in;
    logic       temp_valid;
    logic       stats_clr;
    logic [1:0] alarm_state;
    logic       warn;
    logic       crit;
    logic [7:0] fan_duty;
    logic       irq;
    logic [7:0] temp_min;
    logic [7:0] temp_max;

    temp_alarm_ctrl #(
        .WARN_TH  (8'd60),
        .CRIT_TH  (8'd80),
        .HYST     (8'd5),
        .DEBOUNCE (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .temp_in     (temp_in),
        .temp_valid  (temp_valid),
        .stats_clr   (stats_clr),
        .alarm_state (alarm_state),
        .warn        (warn),
        .crit        (crit),
        .fan_duty    (fan_duty),
        .irq         (irq),
        .temp_min    (temp_min),
        .temp_max    (temp_max)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int   t;
        logic v;
        int   lvl;
        logic irq;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int t, input logic v, input logic c);
        temp_in    = 8'(t);
        temp_valid = v;
        stats_clr  = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step(0, 1'b0, 1'b0);
        rst = 1'b1;
    endtask

    function automatic int duty_for(input int lvl);
        return (lvl == 0) ? 0 : (lvl == 1) ? 128 : 255;
    endfunction

    task automatic chk_level(input string tag, input int lvl, input logic exp_irq);
        chk({tag, ".state"}, int'(alarm_state), lvl);
        chk({tag, ".warn"}, int'(warn), (lvl != 0) ? 1 : 0);
        chk({tag, ".crit"}, int'(crit), (lvl == 2) ? 1 : 0);
        chk({tag, ".fan"}, int'(fan_duty), duty_for(lvl));
        chk({tag, ".irq"}, int'(irq), int'(exp_irq));
    endtask

    // Target level a sample asks for from a given level, -1 if it asks for nothing.
    function automatic int want_level(input int lvl, input int t);
        int lo_w = (WARN_TH - HYST < 0) ? 0 : WARN_TH - HYST;
        int lo_c = (CRIT_TH - HYST < 0) ? 0 : CRIT_TH - HYST;
        if (lvl == 0) begin
            if (t >= CRIT_TH) return 2;
            if (t >= WARN_TH) return 1;
        end else if (lvl == 1) begin
            if (t >= CRIT_TH) return 2;
            if (t < lo_w) return 0;
        end else begin
            if (t < lo_c) return 1;
        end
        return -1;
    endfunction

    function automatic void add(input int t, input logic v, input int lvl, input logic ir);
        vec_t e;
        e.t = t; e.v = v; e.lvl = lvl; e.irq = ir;
        vecs.push_back(e);
    endfunction

    int   m_lvl;
    int   m_run[$];
    logic m_pend;
    logic m_irq;
    int   m_min;
    int   m_max;

    initial begin
        rst = 1'b1; temp_in = 8'd0; temp_valid = 1'b0; stats_clr = 1'b0;

        // warm-up to WARN, WARN->CRIT with an interruption, CRIT->WARN->NORMAL, gapped valid
        for (int i = 0; i < 3; i++) add(65, 1, 0, 0);
        add(65, 1, 1, 0);
        add(0, 0, 1, 1);
        for (int i = 0; i < 3; i++) add(85, 1, 1, 0);
        add(70, 1, 1, 0);
        for (int i = 0; i < 3; i++) add(85, 1, 1, 0);
        add(85, 1, 2, 0);
        add(76, 1, 2, 1);
        for (int i = 0; i < 3; i++) add(76, 1, 2, 0);
        for (int i = 0; i < 3; i++) add(74, 1, 2, 0);
        add(74, 1, 1, 0);
        add(54, 1, 1, 1);
        for (int i = 0; i < 2; i++) add(54, 1, 1, 0);
        add(54, 1, 0, 0);
        add(65, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            add(65, 1, 0, 0);
            add(65, 0, 0, 0);
        end
        add(65, 1, 1, 0);
        add(65, 0, 1, 1);

        do_reset();
        chk_level("reset", 0, 1'b0);
        chk("reset.min", int'(temp_min), RST_MIN);
        chk("reset.max", int'(temp_max), 0);

        foreach (vecs[i]) begin
            step(vecs[i].t, vecs[i].v, 1'b0);
            chk_level($sformatf("vec%0d", i), vecs[i].lvl, vecs[i].irq);
        end

        // reset mid-debounce discards the partial count
        do_reset();
        for (int i = 0; i < 3; i++) step(90, 1'b1, 1'b0);
        chk_level("pre_rst", 0, 1'b0);
        rst = 1'b0;
        step(90, 1'b1, 1'b0);
        rst = 1'b1;
        chk_level("mid_rst", 0, 1'b0);
        step(90, 1'b1, 1'b0);
        chk_level("post_rst1", 0, 1'b0);
        for (int i = 0; i < 2; i++) step(90, 1'b1, 1'b0);
        chk_level("post_rst3", 0, 1'b0);
        step(90, 1'b1, 1'b0);
        chk_level("post_rst4", 2, 1'b0);
        step(90, 1'b1, 1'b0);
        chk_level("post_rst_irq", 2, 1'b1);

        // statistics and clear priority
        do_reset();
        step(40, 1'b1, 1'b0);
        step(20, 1'b1, 1'b0);
        step(90, 1'b1, 1'b0);
        chk("stats.min", int'(temp_min), (RST_MIN == 255) ? 20 : 0);
        chk("stats.max", int'(temp_max), (RST_MIN == 255) ? 90 : 0);
        step(10, 1'b1, 1'b1);
        chk("stats_clr.min", int'(temp_min), RST_MIN);
        chk("stats_clr.max", int'(temp_max), 0);

        // randomized run against the reference model
        do_reset();
        m_lvl = 0; m_run.delete(); m_pend = 0; m_irq = 0; m_min = 255; m_max = 0;
        for (int i = 0; i < 3000; i++) begin
            int   t;
            logic v;
            logic c;
            logic r;
            int   pick;
            int   edge_vals[10];
            edge_vals = '{0, 255, 54, 55, 59, 60, 74, 75, 79, 80};
            pick = $urandom_range(0, 3);
            if (pick == 0) t = $urandom_range(0, 255);
            else if (pick == 3) t = edge_vals[$urandom_range(0, 9)];
            else t = $urandom_range(45, 95);
            v = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 49) == 0);
            r = ($urandom_range(0, 249) != 0);
            rst = r;
            step(t, v, c);
            if (!r) begin
                m_lvl = 0; m_run.delete(); m_pend = 0; m_irq = 0; m_min = 255; m_max = 0;
            end else begin
                int w;
                m_irq  = m_pend;
                m_pend = 0;
                if (v) begin
                    w = want_level(m_lvl, t);
                    if (w < 0) m_run.delete();
                    else begin
                        m_run.push_back(w);
                        if (m_run.size() == DEBOUNCE) begin
                            m_lvl = m_run[$];
                            m_run.delete();
                            m_pend = 1;
                        end
                    end
                end
                if (c) begin
                    m_min = 255; m_max = 0;
                end else if (v) begin
                    if (t < m_min) m_min = t;
                    if (t > m_max) m_max = t;
                end
            end
            chk_level($sformatf("rnd%0d", i), m_lvl, m_irq);
            chk("rnd.min", int'(temp_min), (RST_MIN == 255) ? m_min : 0);
            chk("rnd.max", int'(temp_max), (RST_MIN == 255) ? m_max : 0);
        end
        rst = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
